// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle of signals between the 5-stage RV32I pipeline datapath and its
// hazard controller.
//   master : pipeline side. Drives the register indices, the writeback
//            enables, LoadE, PCSrcE, MulStartE and the data-memory
//            handshake. Receives the stall, flush and forward controls.
//   slave  : controller side. This is the mirror image of master.
// Parameter REG_AW sets the register-index width.
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [REG_AW-1:0] RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic              LoadE, PCSrcE, MulStartE;
    logic              DmemReqM, DmemReadyM;

    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushM, FlushW;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              mul_busy, mul_done;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE,
        output DmemReqM, DmemReadyM,
        input  StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushM, FlushW,
        input  ForwardAE, ForwardBE, mul_busy, mul_done
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MulStartE,
        input  DmemReqM, DmemReadyM,
        output StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushM, FlushW,
        output ForwardAE, ForwardBE, mul_busy, mul_done
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage RV32I pipeline. It drives
// the stall and flush controls of the pipeline registers and the EX-stage
// forwarding selects. A two-state FSM sequences multicycle EX ops (MUL/DIV).
// The controller holds the whole pipeline while the data memory is waiting.
//
// Ports:
//   clk          clock
//   rst          synchronous, active-low reset
//   bus          pipeline_hazard_ctrl_if.slave (hazard inputs, controls out)
//   stall_cycles count of cycles with StallD=1       (HAZ_STATS_EN only)
//   flush_events count of cycles with any Flush*=1   (HAZ_STATS_EN only)
//
// Parameters:
//   MUL_LAT  EX occupancy in cycles of a multicycle op (1..16)
//   REG_AW   register-index width
//
// Optional feature:
//   Define HAZ_STATS_EN to add the stall/flush statistics counters.
//
// Stall overrides Flush inside the pipeline registers. Exactly one priority
// row drives the controls in each cycle, so no register ever sees both.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int REG_AW  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
`ifdef HAZ_STATS_EN
    ,
    output logic [31:0]            stall_cycles,
    output logic [31:0]            flush_events
`endif
);

    localparam bit         MULTI    = (MUL_LAT > 1);
    localparam logic [3:0] CNT_INIT = MULTI ? 4'(MUL_LAT - 2) : 4'd0;

    typedef enum logic {RUN = 1'b0, MUL_WAIT = 1'b1} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       mul_done_q;

    logic mem_stall, lw_stall, mul_start, mul_hold, mul_done;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_m, flush_w;

    // MEM has priority over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_m,
        input logic              we_w
    );
        if (we_m && rd_m != '0 && rd_m == rs)      return 2'b10;
        else if (we_w && rd_w != '0 && rd_w == rs) return 2'b01;
        else                                       return 2'b00;
    endfunction

    always_comb begin
        mem_stall = bus.DmemReqM && !bus.DmemReadyM;
        lw_stall  = bus.LoadE && bus.RdE != '0 &&
                    (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
        // The instruction that has just finished may still show MulStartE
        // in the cycle after mul_done. mul_done_q keeps it from retriggering.
        mul_start = (state == RUN) && bus.MulStartE && MULTI && !mul_done_q;
        mul_hold  = mul_start || (state == MUL_WAIT && cnt != 4'd0);
        mul_done  = (state == MUL_WAIT) && cnt == 4'd0 && !mem_stall;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the priority chain can leave a value held, which would infer a latch.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (mul_hold) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (bus.PCSrcE) begin
            // A branch behind a mem/mul hold falls through to here in the
            // cycle that EX is released.
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign bus.StallF    = stall_f;
    assign bus.StallD    = stall_d;
    assign bus.StallE    = stall_e;
    assign bus.StallM    = stall_m;
    assign bus.FlushD    = flush_d;
    assign bus.FlushE    = flush_e;
    assign bus.FlushM    = flush_m;
    assign bus.FlushW    = flush_w;
    assign bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.RdW,
                                   bus.RegWriteM, bus.RegWriteW);
    assign bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.RdW,
                                   bus.RegWriteM, bus.RegWriteW);
    assign bus.mul_busy  = (state == MUL_WAIT);
    assign bus.mul_done  = mul_done;

    // NOTE: the reset is sampled on the clock edge, so it sits inside the
    // clocked branch. State uses non-blocking assignments so every register
    // updates from values taken before the edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            cnt        <= 4'd0;
            mul_done_q <= 1'b0;
        end else if (!mem_stall) begin
            mul_done_q <= mul_done;
            case (state)
                RUN: begin
                    if (mul_start) begin
                        state <= MUL_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                MUL_WAIT: begin
                    if (cnt != 4'd0) cnt   <= cnt - 4'd1;
                    else             state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (stall_d)
                stall_cycles <= stall_cycles + 32'd1;
            if (flush_d || flush_e || flush_m || flush_w)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule
